// File: rtl/nn_readout_stream_classifier.sv
// Streaming readout classifier: accumulates I/Q per window, hands packed features to an NN core,
// waits (bounded) for the prediction and writes {timeout, prediction} to the result BRAM.
module nn_readout_stream_classifier #(
  parameter int NUM_WINDOWS    = 2,
  parameter int WINDOW_LEN     = 200,
  parameter int IQ_WIDTH_IN    = 14,
  parameter int SHIFT_M        = 7,
  parameter int SHIFT_N        = 1,
  parameter int PRED_BITS      = 2,
  parameter int BRAM_ADDR_BITS = 14,
  parameter int TIMEOUT        = 64,
  localparam int IQ_W     = IQ_WIDTH_IN - SHIFT_M,
  localparam int ACC_W    = IQ_W + $clog2(WINDOW_LEN),
  localparam int FEAT_W   = ACC_W - SHIFT_N,
  localparam int FEAT_TOT = 2 * NUM_WINDOWS * FEAT_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      clear,
  input  logic                      trigger,
  input  logic [31:0]               in_TDATA,
  input  logic                      in_TVALID,
  output logic [FEAT_TOT-1:0]       feat_data,
  output logic                      feat_valid,
  input  logic                      feat_ready,
  input  logic [PRED_BITS-1:0]      pred_data,
  input  logic                      pred_valid,
  output logic [BRAM_ADDR_BITS-1:0] out_ADDR,
  output logic [PRED_BITS:0]        out_DATA,
  output logic                      out_WE,
  output logic                      busy,
  output logic [15:0]               shot_count,
  output logic [15:0]               overrun_count,
  output logic                      wrapped
);

  localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int WIN_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(WINDOW_LEN - 1);
  localparam logic [WIN_W-1:0] LAST_WIN  = WIN_W'(NUM_WINDOWS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, ISSUE, WAIT_PRED, WRITE} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]          samp_cnt;
  logic [WIN_W-1:0]          win_idx;
  logic [TMO_W-1:0]          tmo_cnt;
  logic signed [ACC_W-1:0]   sum_i [NUM_WINDOWS];
  logic signed [ACC_W-1:0]   sum_q [NUM_WINDOWS];
  logic [BRAM_ADDR_BITS-1:0] addr;
  logic [PRED_BITS:0]        wdata;
  logic sample_fire, shot_done, pred_take, tmo_hit;
  logic unused_tdata;

  // Arithmetic drop of SHIFT_M LSBs, then sign extension to accumulator width.
  function automatic logic signed [ACC_W-1:0] trim_sample(input logic [IQ_WIDTH_IN-1:0] raw);
    logic signed [IQ_W-1:0] t;
    t = raw[IQ_WIDTH_IN-1:SHIFT_M];
    return {{(ACC_W-IQ_W){t[IQ_W-1]}}, t};
  endfunction

  // Floor division by 2^SHIFT_N; the accumulator is wide enough that no saturation is needed.
  function automatic logic signed [FEAT_W-1:0] floor_shift(input logic signed [ACC_W-1:0] s);
    return s[ACC_W-1:SHIFT_N];
  endfunction

  assign unused_tdata = ^in_TDATA[31-2*IQ_WIDTH_IN:0];

  always_comb begin
    sample_fire = (state == ACCUM) && in_TVALID;
    shot_done   = sample_fire && (samp_cnt == LAST_SAMP) && (win_idx == LAST_WIN);
    pred_take   = (state == WAIT_PRED) && pred_valid;
    tmo_hit     = (state == WAIT_PRED) && !pred_valid && (tmo_cnt == TMO_LAST);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (trigger) state_nx = ACCUM;
      ACCUM:     if (shot_done) state_nx = ISSUE;
      ISSUE:     if (feat_ready) state_nx = WAIT_PRED;
      WAIT_PRED: if (pred_take || tmo_hit) state_nx = WRITE;
      WRITE:     state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clear) state <= IDLE;
    else                    state <= state_nx;
  end

  // Accumulation stage: per-window running sums, sample and window counters.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clear) begin
      samp_cnt <= '0;
      win_idx  <= '0;
      for (int k = 0; k < NUM_WINDOWS; k++) begin
        sum_i[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (state == IDLE && trigger) begin
      samp_cnt <= '0;
      win_idx  <= '0;
      for (int k = 0; k < NUM_WINDOWS; k++) begin
        sum_i[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (sample_fire) begin
      sum_i[win_idx] <= sum_i[win_idx] + trim_sample(in_TDATA[31 -: IQ_WIDTH_IN]);
      sum_q[win_idx] <= sum_q[win_idx] + trim_sample(in_TDATA[31-IQ_WIDTH_IN -: IQ_WIDTH_IN]);
      if (samp_cnt == LAST_SAMP) begin
        samp_cnt <= '0;
        win_idx  <= (win_idx == LAST_WIN) ? '0 : win_idx + 1'b1;
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

  // Prediction and write stage: timeout counter, result word, address and statistics.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clear) begin
      tmo_cnt       <= '0;
      wdata         <= '0;
      addr          <= '0;
      shot_count    <= '0;
      overrun_count <= '0;
      wrapped       <= 1'b0;
    end else begin
      if (state == WAIT_PRED) tmo_cnt <= tmo_cnt + 1'b1;
      else                    tmo_cnt <= '0;
      if (pred_take)    wdata <= {1'b0, pred_data};
      else if (tmo_hit) wdata <= {1'b1, {PRED_BITS{1'b0}}};
      if (state == WRITE) begin
        addr       <= addr + 1'b1;
        shot_count <= shot_count + 16'd1;
        if (&addr) wrapped <= 1'b1;
      end
      if (trigger && state != IDLE && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
    end
  end

  // Features are pure wiring off the sum registers, which are frozen outside ACCUM.
  for (genvar k = 0; k < NUM_WINDOWS; k++) begin : g_feat
    assign feat_data[2*k*FEAT_W +: FEAT_W]     = floor_shift(sum_i[k]);
    assign feat_data[(2*k+1)*FEAT_W +: FEAT_W] = floor_shift(sum_q[k]);
  end

  assign feat_valid = (state == ISSUE);
  assign out_WE     = (state == WRITE);
  assign busy       = (state != IDLE);
  assign out_ADDR   = addr;
  assign out_DATA   = wdata;

endmodule

// File: tb/tb_nn_readout_stream_classifier.sv
// Directed bench for nn_readout_stream_classifier (defaults except a 4-entry result BRAM so address wrap is reachable).
`timescale 1ns/1ps
module tb_nn_readout_stream_classifier;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, trigger, tvalid, feat_ready, pred_valid;
  logic feat_valid, out_WE, busy, wrapped;
  logic [31:0] tdata;
  logic [1:0]  pred_data;
  logic [55:0] feat_data;
  logic [1:0]  out_ADDR;
  logic [2:0]  out_DATA;
  logic [15:0] shot_count, overrun_count;

  int errors = 0;
  int checks = 0;

  // I=+8191, Q=-8192; per window I=200*63=12600 -> 6300, Q=200*(-64)=-12800 -> -6400.
  localparam logic [31:0] SAMPLE   = {14'h1FFF, 14'h2000, 4'h0};
  localparam logic [55:0] EXP_FEAT = {14'h2700, 14'h189C, 14'h2700, 14'h189C};

  nn_readout_stream_classifier #(.BRAM_ADDR_BITS(2)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .trigger(trigger),
    .in_TDATA(tdata), .in_TVALID(tvalid),
    .feat_data(feat_data), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .pred_data(pred_data), .pred_valid(pred_valid),
    .out_ADDR(out_ADDR), .out_DATA(out_DATA), .out_WE(out_WE), .busy(busy),
    .shot_count(shot_count), .overrun_count(overrun_count), .wrapped(wrapped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_samples(input bit do_trig, input bit gaps, input int n, output int ncyc);
    ncyc = 0;
    tdata = SAMPLE;
    if (do_trig) begin
      trigger = 1'b1; tvalid = 1'b1; tick(); trigger = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b1; tick(); ncyc++;
      if (gaps && i < n - 1) begin
        tvalid = 1'b0; tick(); ncyc++;
      end
    end
    tvalid = 1'b0;
  endtask

  task automatic handshake();
    feat_ready = 1'b1; tick(); feat_ready = 1'b0;
  endtask

  task automatic send_pred(input logic [1:0] p);
    pred_data = p; pred_valid = 1'b1; tick(); pred_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (out_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", out_WE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (feat_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid: got %0b expected 0", feat_valid); end
    checks++; if (feat_data !== 56'h0) begin errors++; $display("FAIL reset_fdata: got %0h expected 0", feat_data); end
    checks++; if ({out_ADDR, out_DATA, wrapped} !== 6'h0) begin errors++; $display("FAIL reset_out: got addr=%0d data=%0b wrapped=%0b expected 0", out_ADDR, out_DATA, wrapped); end
    checks++; if ({shot_count, overrun_count} !== 32'h0) begin errors++; $display("FAIL reset_counts: got shots=%0d overruns=%0d expected 0", shot_count, overrun_count); end
  endtask

  task automatic test_basic();
    int n;
    send_samples(1'b1, 1'b0, 399, n);
    checks++; if (feat_valid !== 1'b0) begin errors++; $display("FAIL basic_fvalid_early: got %0b expected 0", feat_valid); end
    send_samples(1'b0, 1'b0, 1, n);
    checks++; if (feat_valid !== 1'b1) begin errors++; $display("FAIL basic_fvalid: got %0b expected 1", feat_valid); end
    checks++; if (feat_data !== EXP_FEAT) begin errors++; $display("FAIL basic_fdata: got %0h expected %0h", feat_data, EXP_FEAT); end
    handshake();
    checks++; if ({feat_valid, busy} !== 2'b01) begin errors++; $display("FAIL basic_after_hs: got fvalid,busy=%0b expected 01", {feat_valid, busy}); end
    tick(); tick();
    send_pred(2'd2);
    checks++; if ({out_WE, out_DATA, out_ADDR} !== {1'b1, 3'b010, 2'd0}) begin errors++; $display("FAIL basic_write: got we=%0b data=%0b addr=%0d expected we=1 data=010 addr=0", out_WE, out_DATA, out_ADDR); end
    tick();
    checks++; if ({out_WE, busy} !== 2'b00) begin errors++; $display("FAIL basic_we_single: got we,busy=%0b expected 00", {out_WE, busy}); end
    checks++; if (shot_count !== 16'd1 || out_ADDR !== 2'd1) begin errors++; $display("FAIL basic_post: got shots=%0d addr=%0d expected 1 1", shot_count, out_ADDR); end
  endtask

  task automatic test_gaps();
    int n;
    send_samples(1'b1, 1'b1, 400, n);
    checks++; if (n !== 799 || feat_valid !== 1'b1) begin errors++; $display("FAIL gaps_timing: got cycles=%0d fvalid=%0b expected 799 1", n, feat_valid); end
    checks++; if (feat_data !== EXP_FEAT) begin errors++; $display("FAIL gaps_fdata: got %0h expected %0h", feat_data, EXP_FEAT); end
    handshake();
    send_pred(2'd1);
    checks++; if ({out_WE, out_DATA, out_ADDR} !== {1'b1, 3'b001, 2'd1}) begin errors++; $display("FAIL gaps_write: got we=%0b data=%0b addr=%0d expected we=1 data=001 addr=1", out_WE, out_DATA, out_ADDR); end
    tick();
  endtask

  task automatic test_ready_hold();
    int n;
    int unstable = 0;
    int hs = 0;
    send_samples(1'b1, 1'b0, 400, n);
    feat_ready = 1'b0;
    send_pred(2'd3);
    for (int i = 0; i < 9; i++) begin
      if (feat_valid !== 1'b1 || feat_data !== EXP_FEAT || out_WE !== 1'b0) unstable++;
      tick();
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", unstable); end
    feat_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (feat_valid === 1'b1) hs++;
      tick();
    end
    feat_ready = 1'b0;
    checks++; if (hs !== 1) begin errors++; $display("FAIL hold_handshakes: got %0d expected 1", hs); end
    send_pred(2'd3);
    checks++; if ({out_WE, out_DATA, out_ADDR} !== {1'b1, 3'b011, 2'd2}) begin errors++; $display("FAIL hold_write: got we=%0b data=%0b addr=%0d expected we=1 data=011 addr=2", out_WE, out_DATA, out_ADDR); end
    tick();
    checks++; if (shot_count !== 16'd3) begin errors++; $display("FAIL hold_shots: got %0d expected 3", shot_count); end
  endtask

  task automatic test_timeout();
    int n;
    send_samples(1'b1, 1'b0, 400, n);
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_early: got %0b expected 0", wrapped); end
    handshake();
    n = 0;
    while (out_WE !== 1'b1 && n < 200) begin
      tick(); n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 64", n); end
    checks++; if ({out_DATA, out_ADDR} !== {3'b100, 2'd3}) begin errors++; $display("FAIL timeout_write: got data=%0b addr=%0d expected data=100 addr=3", out_DATA, out_ADDR); end
    tick();
    checks++; if ({wrapped, out_ADDR} !== {1'b1, 2'd0} || shot_count !== 16'd4) begin errors++; $display("FAIL wrap_set: got wrapped=%0b addr=%0d shots=%0d expected 1 0 4", wrapped, out_ADDR, shot_count); end
  endtask

  task automatic test_back_to_back();
    int n;
    send_samples(1'b1, 1'b0, 400, n);
    handshake();
    send_pred(2'd0);
    checks++; if ({out_WE, out_DATA, out_ADDR} !== {1'b1, 3'b000, 2'd0}) begin errors++; $display("FAIL fifth_write: got we=%0b data=%0b addr=%0d expected we=1 data=000 addr=0", out_WE, out_DATA, out_ADDR); end
    trigger = 1'b1; tick(); trigger = 1'b0;
    checks++; if (busy !== 1'b0 || overrun_count !== 16'd1) begin errors++; $display("FAIL write_trigger: got busy=%0b overruns=%0d expected 0 1", busy, overrun_count); end
    checks++; if (shot_count !== 16'd5 || out_ADDR !== 2'd1) begin errors++; $display("FAIL fifth_post: got shots=%0d addr=%0d expected 5 1", shot_count, out_ADDR); end
  endtask

  task automatic test_clear();
    int n;
    send_samples(1'b1, 1'b0, 150, n);
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if ({busy, wrapped, out_ADDR} !== 4'b0) begin errors++; $display("FAIL clear_state: got busy=%0b wrapped=%0b addr=%0d expected 0", busy, wrapped, out_ADDR); end
    checks++; if ({shot_count, overrun_count} !== 32'h0 || feat_data !== 56'h0) begin errors++; $display("FAIL clear_counts: got shots=%0d overruns=%0d fdata=%0h expected 0", shot_count, overrun_count, feat_data); end
    send_samples(1'b1, 1'b0, 400, n);
    checks++; if (feat_data !== EXP_FEAT) begin errors++; $display("FAIL clear_fdata: got %0h expected %0h", feat_data, EXP_FEAT); end
    handshake();
    send_pred(2'd2);
    checks++; if ({out_WE, out_DATA, out_ADDR} !== {1'b1, 3'b010, 2'd0}) begin errors++; $display("FAIL clear_write: got we=%0b data=%0b addr=%0d expected we=1 data=010 addr=0", out_WE, out_DATA, out_ADDR); end
    tick();
  endtask

  task automatic test_abort();
    int n;
    int stray = 0;
    send_samples(1'b1, 1'b0, 100, n);
    for (int i = 0; i < 3; i++) begin
      trigger = 1'b1; tvalid = 1'b1; tick();
      trigger = 1'b0; tick();
    end
    checks++; if (overrun_count !== 16'd3 || busy !== 1'b1) begin errors++; $display("FAIL abort_overrun: got overruns=%0d busy=%0b expected 3 1", overrun_count, busy); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if ({out_WE, busy, feat_valid, wrapped, out_ADDR, out_DATA} !== 9'b0 || feat_data !== 56'h0) begin errors++; $display("FAIL abort_outputs: got we=%0b busy=%0b fvalid=%0b addr=%0d data=%0b fdata=%0h expected 0", out_WE, busy, feat_valid, out_ADDR, out_DATA, feat_data); end
    checks++; if ({shot_count, overrun_count} !== 32'h0) begin errors++; $display("FAIL abort_counts: got shots=%0d overruns=%0d expected 0", shot_count, overrun_count); end
    for (int i = 0; i < 450; i++) begin
      pred_valid = (i % 50 == 0);
      feat_ready = 1'b1;
      if (out_WE !== 1'b0 || busy !== 1'b0) stray++;
      tick();
    end
    tvalid = 1'b0; pred_valid = 1'b0; feat_ready = 1'b0;
    checks++; if (stray !== 0) begin errors++; $display("FAIL abort_no_write: got %0d stray cycles expected 0", stray); end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; trigger = 1'b0; tvalid = 1'b0; tdata = 32'h0;
    feat_ready = 1'b0; pred_valid = 1'b0; pred_data = 2'd0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_gaps();
    test_ready_hold();
    test_timeout();
    test_back_to_back();
    test_clear();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nn_readout_stream_classifier.md
Name: nn_readout_stream_classifier

Overview:
Successor to the fixed two-window readout classifier. It accumulates I/Q samples on the fly into NUM_WINDOWS per-window running sums, so no sample memory is needed. On completion it presents a packed feature vector to an external NN core over a valid/ready handshake, waits for the prediction with a timeout, and writes the result and status to PL BRAM. It sits between the QICK readout AXIS stream and the LogicNet core.

Parameters:
NUM_WINDOWS, 2, number of integration windows per shot (>=1).
WINDOW_LEN, 200, samples per window; a shot is NUM_WINDOWS*WINDOW_LEN samples.
IQ_WIDTH_IN, 14, raw signed I/Q width; I=in_TDATA[31:18], Q=in_TDATA[17:4].
SHIFT_M, 7, LSBs dropped per sample before accumulation (arithmetic); IQ_W=IQ_WIDTH_IN-SHIFT_M.
SHIFT_N, 1, LSBs dropped from each window sum (arithmetic); FEAT_W=ACC_W-SHIFT_N.
PRED_BITS, 2, NN prediction width.
BRAM_ADDR_BITS, 14, result BRAM depth is 2^BRAM_ADDR_BITS.
TIMEOUT, 64, maximum cycles in WAIT_PRED before forcing a timeout write.
Derived: ACC_W=IQ_W+$clog2(WINDOW_LEN); FEAT_TOT=2*NUM_WINDOWS*FEAT_W.

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  synchronous, active-low reset
clear  in  1  synchronous soft clear: address, shot_count, overrun_count, wrapped to 0; FSM to IDLE
trigger  in  1  start of a shot (single-cycle pulse)
in_TDATA  in  32  sample word
in_TVALID  in  1  sample qualifier; no backpressure
feat_data  out  FEAT_TOT  packed features; window k: I at [2k*FEAT_W +: FEAT_W], Q at [(2k+1)*FEAT_W +: FEAT_W]
feat_valid  out  1  feature vector valid
feat_ready  in  1  NN accepts features
pred_data  in  PRED_BITS  NN prediction
pred_valid  in  1  prediction valid (single-cycle)
out_ADDR  out  BRAM_ADDR_BITS  write address
out_DATA  out  PRED_BITS+1  {timeout_flag, prediction}
out_WE  out  1  write enable, one cycle per shot
busy  out  1  high in any state other than IDLE
shot_count  out  16  completed writes; wraps
overrun_count  out  16  triggers ignored while busy; saturates at 0xFFFF
wrapped  out  1  sticky; set when out_ADDR wraps from max to 0

Behaviour:
- Reset (ap_rst_n=0 at a clock edge): FSM IDLE; all outputs, sums, counters, and address are 0. clear has the same effect on the listed registers, and also on the FSM and sums.
- States: IDLE -> ACCUM on trigger. ACCUM -> ISSUE after the final sample is accepted. ISSUE -> WAIT_PRED on feat_valid&&feat_ready. WAIT_PRED -> WRITE on pred_valid, or when the timeout counter reaches TIMEOUT. WRITE -> IDLE after one cycle.
- ACCUM: each in_TVALID cycle adds sign-extended I[13:SHIFT_M] and Q[13:SHIFT_M] into window win_idx. The sample counter runs 0..WINDOW_LEN-1 and then advances win_idx. Gaps in in_TVALID stall accumulation; there is no timeout in ACCUM. in_TVALID in the trigger cycle is ignored.
- Sums are zeroed on IDLE->ACCUM. ACC_W is sized so sums never overflow.
- Features are sum>>>SHIFT_N (floor). They are registered and held stable while feat_valid=1. feat_valid rises the cycle after the last sample is accepted. It stays high until accepted and drops the cycle after the handshake.
- WAIT_PRED: the cycle counter starts at 0 on entry. If pred_valid arrives at count<TIMEOUT, out_DATA={0,pred_data}. If the counter reaches TIMEOUT, out_DATA={1,0}.
- WRITE: out_WE=1 for exactly one cycle with out_ADDR and out_DATA stable. The address increments after the write. Max wraps to 0 and sets wrapped. shot_count increments. The first write after reset or clear goes to address 0.
- A pred_valid seen outside WAIT_PRED is ignored.
- A trigger while busy is ignored and increments overrun_count, including a trigger in the WRITE cycle.
- clear and reset take priority over every event, including mid-shot. No out_WE is issued for an aborted shot.

Test Plan:
- Defaults, constant I=+8191, Q=-8192 for 400 samples: features I0=I1=6300 (0x189C in 14b), Q0=Q1=-6400 (0x2700). feat_valid rises 1 cycle after the last sample. pred_data=2: out_DATA=3'b010, out_ADDR=0, out_WE a single cycle.
- Same shot with in_TVALID toggling 1/0: identical features; shot takes about 800 ACCUM cycles.
- feat_ready held low for 10 cycles: feat_valid and feat_data stable throughout; exactly one handshake.
- No pred_valid: write at TIMEOUT (64) cycles after WAIT_PRED entry with out_DATA=3'b100.
- BRAM_ADDR_BITS=2, 5 shots: addresses 0,1,2,3,0; wrapped=1 after the 4th write; shot_count=5.
- Trigger pulsed 3 times mid-ACCUM, then ap_rst_n=0 mid-ACCUM: overrun_count=3 before reset; after reset all outputs are 0 and no out_WE is issued.
